// File: rtl/coolgirl_cfg_ctrl.sv
// COOLGIRL configuration controller: shadow register file at $5000-$5007, a timed
// bus hold on commit, an atomic shadow-to-active transfer and a one-way lockout.
module coolgirl_cfg_ctrl #(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [7:0] COMMIT_KEY  = 8'hA5
) (
    input  logic        m2,
    input  logic        rst_n,
    input  logic        romsel,
    input  logic        cpu_rw_in,
    input  logic [14:0] cpu_addr_in,
    input  logic [7:0]  cpu_data_in,
    output logic [12:0] cpu_base,
    output logic [6:0]  prg_mask,
    output logic [4:0]  chr_mask,
    output logic [4:0]  mapper,
    output logic        sram_enabled,
    output logic        prg_write_enabled,
    output logic        chr_write_enabled,
    output logic        map_rom_on_6000,
    output logic        four_screen,
    output logic [1:0]  sram_page,
    output logic        bus_hold,
    output logic        cfg_locked
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0]  HOLD_LOAD      = 4'(HOLD_CYCLES - 1);
    localparam logic [6:0]  RST_PRG_MASK   = 7'h7E;
    localparam logic [4:0]  RST_CHR_MASK   = 5'h1F;
    // Flag order {four_screen, map_rom_on_6000, chr_we, prg_we, sram_en}
    localparam logic [4:0]  RST_FLAGS      = 5'b00010;

    state_t      state_q, state_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic        bus_hold_q, bus_hold_d;
    logic        locked_q, locked_d;

    logic [12:0] sh_base_q, sh_base_d;
    logic [6:0]  sh_prg_mask_q, sh_prg_mask_d;
    logic [4:0]  sh_chr_mask_q, sh_chr_mask_d;
    logic [4:0]  sh_mapper_q, sh_mapper_d;
    logic [4:0]  sh_flags_q, sh_flags_d;
    logic        sh_lock_q, sh_lock_d;
    logic [1:0]  sh_sram_page_q, sh_sram_page_d;

    logic [12:0] act_base_q, act_base_d;
    logic [6:0]  act_prg_mask_q, act_prg_mask_d;
    logic [4:0]  act_chr_mask_q, act_chr_mask_d;
    logic [4:0]  act_mapper_q, act_mapper_d;
    logic [4:0]  act_flags_q, act_flags_d;
    logic [1:0]  act_sram_page_q, act_sram_page_d;

    logic        reg_wr;
    logic [2:0]  reg_idx;

    assign reg_wr  = romsel && !cpu_rw_in && (cpu_addr_in[14:12] == 3'b101)
                     && (cpu_addr_in[11:3] == 9'd0);
    assign reg_idx = cpu_addr_in[2:0];

    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        bus_hold_d      = bus_hold_q;
        locked_d        = locked_q;
        sh_base_d       = sh_base_q;
        sh_prg_mask_d   = sh_prg_mask_q;
        sh_chr_mask_d   = sh_chr_mask_q;
        sh_mapper_d     = sh_mapper_q;
        sh_flags_d      = sh_flags_q;
        sh_lock_d       = sh_lock_q;
        sh_sram_page_d  = sh_sram_page_q;
        act_base_d      = act_base_q;
        act_prg_mask_d  = act_prg_mask_q;
        act_chr_mask_d  = act_chr_mask_q;
        act_mapper_d    = act_mapper_q;
        act_flags_d     = act_flags_q;
        act_sram_page_d = act_sram_page_q;

        case (state_q)
            ST_IDLE: begin
                if (reg_wr) begin
                    case (reg_idx)
                        3'd0: sh_base_d[12:8] = cpu_data_in[4:0];
                        3'd1: sh_base_d[7:0]  = cpu_data_in;
                        3'd2: sh_prg_mask_d   = cpu_data_in[6:0];
                        3'd3: sh_chr_mask_d   = cpu_data_in[4:0];
                        3'd4: sh_mapper_d     = cpu_data_in[4:0];
                        3'd5: begin
                            sh_flags_d = cpu_data_in[4:0];
                            sh_lock_d  = cpu_data_in[7];
                        end
                        3'd6: sh_sram_page_d  = cpu_data_in[1:0];
                        default: begin
                            if (cpu_data_in == COMMIT_KEY) begin
                                state_d    = ST_HOLD;
                                hold_cnt_d = HOLD_LOAD;
                                bus_hold_d = 1'b1;
                            end
                        end
                    endcase
                end
            end
            ST_HOLD: begin
                // Writes are ignored for the whole window, including the final edge
                if (hold_cnt_q == 4'd0) begin
                    act_base_d      = sh_base_q;
                    act_prg_mask_d  = sh_prg_mask_q;
                    act_chr_mask_d  = sh_chr_mask_q;
                    act_mapper_d    = sh_mapper_q;
                    act_flags_d     = sh_flags_q;
                    act_sram_page_d = sh_sram_page_q;
                    bus_hold_d      = 1'b0;
                    locked_d        = sh_lock_q;
                    state_d         = sh_lock_q ? ST_LOCKED : ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 4'd1;
                end
            end
            ST_LOCKED: begin
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge m2 or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            hold_cnt_q      <= 4'd0;
            bus_hold_q      <= 1'b0;
            locked_q        <= 1'b0;
            sh_base_q       <= 13'd0;
            sh_prg_mask_q   <= RST_PRG_MASK;
            sh_chr_mask_q   <= RST_CHR_MASK;
            sh_mapper_q     <= 5'd0;
            sh_flags_q      <= RST_FLAGS;
            sh_lock_q       <= 1'b0;
            sh_sram_page_q  <= 2'd0;
            act_base_q      <= 13'd0;
            act_prg_mask_q  <= RST_PRG_MASK;
            act_chr_mask_q  <= RST_CHR_MASK;
            act_mapper_q    <= 5'd0;
            act_flags_q     <= RST_FLAGS;
            act_sram_page_q <= 2'd0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            bus_hold_q      <= bus_hold_d;
            locked_q        <= locked_d;
            sh_base_q       <= sh_base_d;
            sh_prg_mask_q   <= sh_prg_mask_d;
            sh_chr_mask_q   <= sh_chr_mask_d;
            sh_mapper_q     <= sh_mapper_d;
            sh_flags_q      <= sh_flags_d;
            sh_lock_q       <= sh_lock_d;
            sh_sram_page_q  <= sh_sram_page_d;
            act_base_q      <= act_base_d;
            act_prg_mask_q  <= act_prg_mask_d;
            act_chr_mask_q  <= act_chr_mask_d;
            act_mapper_q    <= act_mapper_d;
            act_flags_q     <= act_flags_d;
            act_sram_page_q <= act_sram_page_d;
        end
    end

    assign cpu_base          = act_base_q;
    assign prg_mask          = act_prg_mask_q;
    assign chr_mask          = act_chr_mask_q;
    assign mapper            = act_mapper_q;
    assign sram_enabled      = act_flags_q[0];
    assign prg_write_enabled = act_flags_q[1];
    assign chr_write_enabled = act_flags_q[2];
    assign map_rom_on_6000   = act_flags_q[3];
    assign four_screen       = act_flags_q[4];
    assign sram_page         = act_sram_page_q;
    assign bus_hold          = bus_hold_q;
    assign cfg_locked        = locked_q;

endmodule

// File: tb/tb_coolgirl_cfg_ctrl.sv
// Bench for coolgirl_cfg_ctrl: a vector table, hand-written corner sequences and
// random traffic against a register-array reference model.
module tb_coolgirl_cfg_ctrl;

   localparam int         HOLD = 4;
   localparam logic [7:0] KEY  = 8'hA5;

   logic        m2;
   logic        rstN;
   logic        romsel;
   logic        cpuRw;
   logic [14:0] cpuAddr;
   logic [7:0]  cpuData;

   logic [12:0] base0;
   logic [6:0]  prgMask0;
   logic [4:0]  chrMask0;
   logic [4:0]  mapper0;
   logic        sramEn0, prgWe0, chrWe0, mapRom0, fourScr0;
   logic [1:0]  sramPage0;
   logic        busHold0, locked0;
   logic [4:0]  flags0;

   logic [12:0] base1;
   logic [6:0]  prgMask1;
   logic [4:0]  chrMask1;
   logic [4:0]  mapper1;
   logic        sramEn1, prgWe1, chrWe1, mapRom1, fourScr1;
   logic [1:0]  sramPage1;
   logic        busHold1, locked1;
   logic [4:0]  flags1;

   int checks = 0;
   int errors = 0;

   coolgirl_cfg_ctrl #(.HOLD_CYCLES(HOLD), .COMMIT_KEY(KEY)) dut0 (
      .m2(m2), .rst_n(rstN), .romsel(romsel), .cpu_rw_in(cpuRw),
      .cpu_addr_in(cpuAddr), .cpu_data_in(cpuData),
      .cpu_base(base0), .prg_mask(prgMask0), .chr_mask(chrMask0), .mapper(mapper0),
      .sram_enabled(sramEn0), .prg_write_enabled(prgWe0), .chr_write_enabled(chrWe0),
      .map_rom_on_6000(mapRom0), .four_screen(fourScr0), .sram_page(sramPage0),
      .bus_hold(busHold0), .cfg_locked(locked0)
   );

   // A one-cycle-hold instance shares the bus to cover the shortest window
   coolgirl_cfg_ctrl #(.HOLD_CYCLES(1), .COMMIT_KEY(KEY)) dut1 (
      .m2(m2), .rst_n(rstN), .romsel(romsel), .cpu_rw_in(cpuRw),
      .cpu_addr_in(cpuAddr), .cpu_data_in(cpuData),
      .cpu_base(base1), .prg_mask(prgMask1), .chr_mask(chrMask1), .mapper(mapper1),
      .sram_enabled(sramEn1), .prg_write_enabled(prgWe1), .chr_write_enabled(chrWe1),
      .map_rom_on_6000(mapRom1), .four_screen(fourScr1), .sram_page(sramPage1),
      .bus_hold(busHold1), .cfg_locked(locked1)
   );

   assign flags0 = {fourScr0, mapRom0, chrWe0, prgWe0, sramEn0};
   assign flags1 = {fourScr1, mapRom1, chrWe1, prgWe1, sramEn1};

   // M2 clock; inputs change on the rising edge, state moves on the falling edge
   initial begin
      m2 = 1'b1;
      forever #5 m2 = ~m2;
   end

   // Watchdog so the run always ends
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog timeout");
      $fatal(1, "[TB] timeout");
   end

   // Reference model: registers as plain bytes, commit as a countdown of edges
   logic [7:0] mShadow [0:6];
   logic [7:0] mActive [0:6];
   logic [7:0] mMask   [0:6];
   int         mHoldLeft;
   bit         mLocked;

   task automatic modelReset();
      mMask[0] = 8'h1F; mMask[1] = 8'hFF; mMask[2] = 8'h7F; mMask[3] = 8'h1F;
      mMask[4] = 8'h1F; mMask[5] = 8'h9F; mMask[6] = 8'h03;
      mShadow[0] = 8'h00; mShadow[1] = 8'h00; mShadow[2] = 8'h7E; mShadow[3] = 8'h1F;
      mShadow[4] = 8'h00; mShadow[5] = 8'h02; mShadow[6] = 8'h00;
      mActive   = mShadow;
      mHoldLeft = 0;
      mLocked   = 1'b0;
   endtask

   task automatic modelEdge(input logic [14:0] addr, input logic [7:0] data,
                            input logic rw, input logic rs);
      int idx;
      bit isWrite;
      isWrite = rs && !rw && (addr >= 15'h5000) && (addr <= 15'h5007);
      if (mLocked) return;
      if (mHoldLeft > 0) begin
         mHoldLeft--;
         if (mHoldLeft == 0) begin
            mActive = mShadow;
            mLocked = mShadow[5][7];
         end
         return;
      end
      if (isWrite) begin
         idx = int'(addr) - 'h5000;
         if (idx < 7) mShadow[idx] = data & mMask[idx];
         else if (data == KEY) mHoldLeft = HOLD;
      end
   endtask

   task automatic checkOutput(input string name, input int unsigned actual,
                              input int unsigned expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
      end
   endtask

   task automatic checkAgainstModel();
      logic [12:0] expBase;
      logic [7:0]  b0, b1, b2, b3, b4, b5, b6;
      b0 = mActive[0]; b1 = mActive[1]; b2 = mActive[2]; b3 = mActive[3];
      b4 = mActive[4]; b5 = mActive[5]; b6 = mActive[6];
      expBase = {b0[4:0], b1};
      checkOutput("rnd_base",     base0,     expBase);
      checkOutput("rnd_prg_mask", prgMask0,  b2[6:0]);
      checkOutput("rnd_chr_mask", chrMask0,  b3[4:0]);
      checkOutput("rnd_mapper",   mapper0,   b4[4:0]);
      checkOutput("rnd_flags",    flags0,    b5[4:0]);
      checkOutput("rnd_sram_pg",  sramPage0, b6[1:0]);
      checkOutput("rnd_bus_hold", busHold0,  (mHoldLeft > 0) ? 1 : 0);
      checkOutput("rnd_locked",   locked0,   mLocked ? 1 : 0);
   endtask

   // One M2 cycle: drive on the rising edge, sample just after the falling edge
   task automatic applyStimulus(input logic [14:0] addr, input logic [7:0] data,
                                input logic rw, input logic rs);
      @(posedge m2);
      cpuAddr = addr;
      cpuData = data;
      cpuRw   = rw;
      romsel  = rs;
      @(negedge m2);
      #1;
      modelEdge(addr, data, rw, rs);
   endtask

   task automatic writeReg(input logic [14:0] addr, input logic [7:0] data);
      applyStimulus(addr, data, 1'b0, 1'b1);
   endtask

   task automatic idleCycle();
      applyStimulus(15'h0000, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic doReset();
      @(posedge m2);
      romsel  = 1'b0;
      cpuRw   = 1'b1;
      rstN    = 1'b0;
      modelReset();
      repeat (2) @(posedge m2);
      rstN = 1'b1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_base"},     base0,     13'h0000);
      checkOutput({tag, "_prg_mask"}, prgMask0,  7'h7E);
      checkOutput({tag, "_chr_mask"}, chrMask0,  5'h1F);
      checkOutput({tag, "_mapper"},   mapper0,   5'h00);
      checkOutput({tag, "_flags"},    flags0,    5'b00010);
      checkOutput({tag, "_sram_pg"},  sramPage0, 2'd0);
      checkOutput({tag, "_bus_hold"}, busHold0,  1'b0);
      checkOutput({tag, "_locked"},   locked0,   1'b0);
   endtask

   typedef struct {
      logic [14:0] addr;
      logic [7:0]  data;
      logic        rw;
      logic        rs;
      logic        expHold;
      logic [12:0] expBase;
      logic [6:0]  expPrg;
   } vec_t;

   vec_t vecs [0:15];

   function automatic vec_t mkVec(input logic [14:0] a, input logic [7:0] d,
                                  input logic rw, input logic rs, input logic h,
                                  input logic [12:0] b, input logic [6:0] p);
      vec_t v;
      v.addr = a; v.data = d; v.rw = rw; v.rs = rs;
      v.expHold = h; v.expBase = b; v.expPrg = p;
      return v;
   endfunction

   initial begin
      vecs[0]  = mkVec(15'h5001, 8'h3C, 0, 1, 0, 13'h0000, 7'h7E);
      vecs[1]  = mkVec(15'h5002, 8'h70, 0, 1, 0, 13'h0000, 7'h7E);
      vecs[2]  = mkVec(15'h5007, 8'hA5, 0, 1, 1, 13'h0000, 7'h7E);
      vecs[3]  = mkVec(15'h0000, 8'h00, 1, 0, 1, 13'h0000, 7'h7E);
      vecs[4]  = mkVec(15'h0000, 8'h00, 1, 0, 1, 13'h0000, 7'h7E);
      vecs[5]  = mkVec(15'h0000, 8'h00, 1, 0, 1, 13'h0000, 7'h7E);
      vecs[6]  = mkVec(15'h0000, 8'h00, 1, 0, 0, 13'h003C, 7'h70);
      vecs[7]  = mkVec(15'h5007, 8'h5A, 0, 1, 0, 13'h003C, 7'h70);
      vecs[8]  = mkVec(15'h5008, 8'h1F, 0, 1, 0, 13'h003C, 7'h70);
      vecs[9]  = mkVec(15'h4000, 8'h1F, 0, 1, 0, 13'h003C, 7'h70);
      vecs[10] = mkVec(15'h5000, 8'h1F, 1, 1, 0, 13'h003C, 7'h70);
      vecs[11] = mkVec(15'h5000, 8'h1F, 0, 0, 0, 13'h003C, 7'h70);
      vecs[12] = mkVec(15'h5007, 8'hA5, 0, 1, 1, 13'h003C, 7'h70);
      vecs[13] = mkVec(15'h0000, 8'h00, 1, 0, 1, 13'h003C, 7'h70);
      vecs[14] = mkVec(15'h0000, 8'h00, 1, 0, 1, 13'h003C, 7'h70);
      vecs[15] = mkVec(15'h0000, 8'h00, 1, 0, 1, 13'h003C, 7'h70);

      rstN    = 1'b0;
      romsel  = 1'b0;
      cpuRw   = 1'b1;
      cpuAddr = 15'h0000;
      cpuData = 8'h00;
      modelReset();
      doReset();
      #1;
      checkResetOutputs("reset");

      $display("[TB] vector table");
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].rw, vecs[i].rs);
         checkOutput($sformatf("vec%0d_bus_hold", i), busHold0, vecs[i].expHold);
         checkOutput($sformatf("vec%0d_base", i),     base0,    vecs[i].expBase);
         checkOutput($sformatf("vec%0d_prg_mask", i), prgMask0, vecs[i].expPrg);
      end
      idleCycle();
      checkOutput("ignored_writes_bus_hold", busHold0, 0);
      checkOutput("ignored_writes_base",     base0,    13'h003C);
      checkOutput("ignored_writes_mapper",   mapper0,  5'h00);

      $display("[TB] writes during hold");
      writeReg(15'h5004, 8'h0A);
      writeReg(15'h5007, KEY);
      checkOutput("hold_start", busHold0, 1);
      writeReg(15'h5004, 8'h1F);
      writeReg(15'h5007, KEY);
      idleCycle();
      checkOutput("hold_mid_mapper", mapper0, 5'h00);
      writeReg(15'h5004, 8'h1F);
      checkOutput("hold_end_bus_hold", busHold0, 0);
      checkOutput("hold_end_mapper",   mapper0,  5'h0A);
      for (int k = 0; k < 4; k++) begin
         idleCycle();
         checkOutput($sformatf("single_window_%0d", k), busHold0, 0);
      end

      $display("[TB] lockout");
      writeReg(15'h5005, 8'h81);
      writeReg(15'h5007, KEY);
      repeat (3) idleCycle();
      checkOutput("lock_pre_locked", locked0, 0);
      idleCycle();
      checkOutput("lock_flags",    flags0,   5'b00001);
      checkOutput("lock_locked",   locked0,  1);
      checkOutput("lock_mapper",   mapper0,  5'h0A);
      checkOutput("lock_bus_hold", busHold0, 0);
      writeReg(15'h5004, 8'h05);
      writeReg(15'h5007, KEY);
      checkOutput("locked_commit_bus_hold", busHold0, 0);
      idleCycle();
      checkOutput("locked_mapper", mapper0, 5'h0A);
      checkOutput("locked_still",  locked0, 1);

      $display("[TB] reset during hold");
      doReset();
      writeReg(15'h5004, 8'h1F);
      writeReg(15'h5007, KEY);
      idleCycle();
      idleCycle();
      checkOutput("midhold_bus_hold_before", busHold0, 1);
      rstN = 1'b0;
      modelReset();
      #2;
      checkResetOutputs("midhold_reset");
      checkOutput("midhold_reset_dut1_mapper", mapper1, 5'h00);
      @(posedge m2);
      @(posedge m2);
      rstN = 1'b1;

      $display("[TB] default commit and one-cycle hold");
      writeReg(15'h5007, KEY);
      checkOutput("dflt_bus_hold0", busHold0, 1);
      checkOutput("dflt_bus_hold1", busHold1, 1);
      idleCycle();
      checkOutput("dflt_h1_bus_hold_fall", busHold1, 0);
      checkOutput("dflt_h4_bus_hold_still", busHold0, 1);
      repeat (3) idleCycle();
      checkResetOutputs("dflt_commit");
      writeReg(15'h5004, 8'h03);
      writeReg(15'h5007, KEY);
      checkOutput("h1_bus_hold_rise", busHold1, 1);
      checkOutput("h1_mapper_before", mapper1,  5'h00);
      idleCycle();
      checkOutput("h1_bus_hold_fall", busHold1, 0);
      checkOutput("h1_mapper_after",  mapper1,  5'h03);
      checkOutput("h1_others", {base1, prgMask1, chrMask1, flags1, sramPage1, locked1},
                  {13'h0000, 7'h7E, 5'h1F, 5'b00010, 2'd0, 1'b0});

      $display("[TB] random traffic");
      for (int n = 0; n < 400; n++) begin
         logic [14:0] a;
         logic [7:0]  d;
         logic        rw, rs;
         if ($urandom_range(0, 9) < 8) a = 15'h5000 + 15'($urandom_range(0, 7));
         else a = 15'($urandom);
         d = 8'($urandom);
         if (a == 15'h5007 && $urandom_range(0, 1) == 1) d = KEY;
         if (a == 15'h5005 && $urandom_range(0, 63) != 0) d[7] = 1'b0;
         rw = ($urandom_range(0, 7) == 0);
         rs = ($urandom_range(0, 7) != 0);
         applyStimulus(a, d, rw, rs);
         checkAgainstModel();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/coolgirl_cfg_ctrl.md
# coolgirl_cfg_ctrl

Configuration controller for the COOLGIRL multicart. It decodes CPU writes in the $5000-$5007 window into a shadow register file. On a commit command, it holds the cartridge bus off for a fixed number of M2 cycles, then atomically transfers the shadow set into the active configuration that drives PRG/CHR base and mask, the mapper select and the memory-enable flags. It also implements a one-way lockout so a launched game cannot rewrite the mapping.

## Interface
Parameters:
- HOLD_CYCLES, 4: M2 cycles the bus is held before the active set updates; legal range 1..15.
- COMMIT_KEY, 8'hA5: data value that must be written to register 7 to trigger a commit.

Ports:
- m2  in  1  CPU M2 clock; all state updates on the falling edge of m2.
- rst_n  in  1  reset; asynchronous, active-low.
- romsel  in  1  /ROMSEL; high for CPU accesses below $8000.
- cpu_rw_in  in  1  CPU R/W; 0 = write.
- cpu_addr_in  in  15  CPU A14..A0.
- cpu_data_in  in  8  CPU data bus, sampled on writes.
- cpu_base  out  13  active PRG base, bits [26:14].
- prg_mask  out  7  active PRG mask, bits [20:14]; 1 = bit forced from base.
- chr_mask  out  5  active CHR mask, bits [17:13].
- mapper  out  5  active mapper select.
- sram_enabled, prg_write_enabled, chr_write_enabled, map_rom_on_6000, four_screen  out  1 each  active flags.
- sram_page  out  2  active SRAM page.
- bus_hold  out  1  1 = top level must force flash_ce/sram_ce inactive.
- cfg_locked  out  1  lockout active.

## Operation
Write decode:
- A register write occurs when romsel=1, cpu_rw_in=0, cpu_addr_in[14:12]=3'b101 and cpu_addr_in[11:3]=0.
- The index is cpu_addr_in[2:0].
- Addresses $5008-$5FFF are ignored.

Shadow registers:
- idx0: [4:0] = base[26:22].
- idx1: [7:0] = base[21:14].
- idx2: [6:0] = prg_mask.
- idx3: [4:0] = chr_mask.
- idx4: [4:0] = mapper.
- idx5 flags: bit0 sram_enabled, bit1 prg_write_enabled, bit2 chr_write_enabled, bit3 map_rom_on_6000, bit4 four_screen, bit7 lock request.
- idx6: [1:0] = sram_page.
- Unused data bits are discarded.
- idx7 is the commit register with no storage. A write equal to COMMIT_KEY starts a commit; any other value is ignored.

FSM states:
- IDLE: shadow writes accepted.
  - Commit key written -> HOLD, with hold counter loaded to HOLD_CYCLES-1 and bus_hold=1.
- HOLD: all $5000-$5007 writes are ignored, including further commits.
  - Counter decrements each edge.
  - When the counter is 0 at an edge: active <= shadow, bus_hold=0, cfg_locked <= shadow lock bit. Next state is LOCKED if the lock bit is set, else IDLE.
- LOCKED: every write ignored, outputs frozen until rst_n low. Terminal state.

Reset values, identical for shadow and active:
- base 0, prg_mask 7'h7E, chr_mask 5'h1F, mapper 0, sram_page 0.
- Flags: prg_write_enabled=1, all other flags 0, lock request 0.
- bus_hold=0, cfg_locked=0, state IDLE.

Other rules:
- Active outputs change only on the commit edge, all bits on the same edge.
- Reads of $5000-$5007 have no effect, and the block never drives the data bus.
- A shadow write in the same cycle that HOLD completes is ignored.

## Timing
- Commit write sampled at falling edge N: bus_hold rises after edge N.
- Active update and bus_hold fall occur after edge N+HOLD_CYCLES.
- HOLD_CYCLES=1 gives a one-cycle hold.
- Shadow write at edge N is visible in shadow after N. A commit at N+1 uses it.
- rst_n asserted mid-HOLD: immediate asynchronous return to reset values, bus_hold=0 without waiting for an edge.
- rst_n release: first functional edge is the next falling m2.

## Test plan
- Reset, then check outputs: prg_mask=7'h7E, chr_mask=5'h1F, flags=5'b00010, bus_hold=0, cfg_locked=0.
- Write $5001=8'h3C, $5002=8'h70, then $5007=8'hA5 with HOLD_CYCLES=4 -> bus_hold high exactly 4 edges; then cpu_base=13'h003C and prg_mask=7'h70 appear on the same edge, with no earlier change.
- Write $5007=8'h5A -> no state change, bus_hold stays 0. Write $5008 and $4000 -> shadow unchanged; verify with a later commit.
- During HOLD: write $5004=8'h1F and a second $5007=8'hA5 -> mapper keeps its pre-HOLD shadow value, and only one hold window occurs.
- Write $5005=8'h81 then commit -> sram_enabled=1, cfg_locked=1. Then write $5004=8'h05 and $5007=8'hA5 -> no bus_hold, mapper unchanged.
- Assert rst_n low mid-HOLD -> bus_hold drops immediately, all registers at reset values, and a post-reset commit of the default shadow leaves outputs unchanged.
